rr_arbiter: RTL and testbench
=============================

# rr_arbiter

- Round-robin arbiter with grant locking that shares one downstream resource among `NREQ` requesters.
- Generalises the fixed-priority two-requester grant logic into a fair, N-way scheduler.
- Enforces a one-cycle turnaround gap between owners, and optionally preempts an owner that holds the resource too long.
- Sits between requesting masters and the shared datapath port; the one-hot `grant` drives the datapath's input mux select.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per owner; only used when hold limiting is compiled in. Range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `req`  in  NREQ  per-requester request level; held high for the whole transaction.
- `grant`  out  NREQ  one-hot grant, registered; all zero when no owner.
- `grant_valid`  out  1  OR of `grant`, registered.
- `grant_id`  out  $clog2(NREQ)  index of the current owner; 0 when `grant_valid`=0.
- `preempt`  out  1  single-cycle pulse when an owner is forcibly released by the hold limit; always 0 when hold limiting is compiled out.

## Operation
- **States:**
  - IDLE: no owner.
  - OWN: grant held.
  - GAP: one-cycle turnaround, no owner.
- **Priority pointer `ptr`** (`$clog2(NREQ)` bits):
  - Selection scans `ptr`, `ptr+1`, …, `ptr+NREQ-1` modulo `NREQ`; the first requester found with `req` high wins.
  - On every release, `ptr` is set to owner+1 modulo `NREQ` (wrap from `NREQ-1` to 0).
- **IDLE:**
  - If any `req` is high, pick a winner, load `grant`/`grant_id`, clear the hold counter, go to OWN.
  - Otherwise stay in IDLE.
- **OWN, release:** release occurs when `req[owner]`=0, or when the hold limit is reached.
  - Clear `grant`, update `ptr`, go to GAP.
- **OWN, hold:** otherwise the grant is held and the hold counter increments, saturating at `MAX_HOLD`.
- **GAP:**
  - Always exactly one cycle.
  - Then behaves exactly like IDLE: arbitrate on the current `req` using the updated `ptr`.
- **Requests:**
  - `req` of non-owners is ignored during OWN and GAP.
  - No requests are queued; a requester must keep `req` high until granted.
- **Hold limit:** the hold counter counts grant cycles of the current owner, and release fires when it reaches `MAX_HOLD`. A preempted owner whose `req` stays high competes again at lowest priority.
- **Simultaneous events:**
  - If the owner drops `req` on the same cycle the limit is reached, it is a normal release and `preempt`=0.
  - If all requesters are active, owners cycle strictly 0→1→…→`NREQ-1`→0.
- **Reset (any time, including mid-grant):**
  - State=IDLE, `grant`=0, `grant_valid`=0, `grant_id`=0, `preempt`=0, `ptr`=0, hold counter=0.

## Timing
- Arbitration latency: `req` sampled high at edge k in IDLE gives `grant` high after edge k, first visible in cycle k+1.
- Release latency: `req[owner]` low at edge k gives `grant` low after edge k. GAP occupies cycle k+1; the next owner's grant is visible in cycle k+2.
- Back-to-back owner switch costs exactly one dead cycle.
- Hold limit: `grant` is high for exactly `MAX_HOLD` cycles, then drops. `preempt` is high in the first GAP cycle, coincident with `grant`=0.
- All outputs are registered; there is no combinational path from `req` to any output.

## Configuration
- Macro `RR_ARBITER_HOLD_LIMIT_EN`.
- **Defined:** the hold counter, `MAX_HOLD` preemption and `preempt` pulse are implemented.
- **Undefined:**
  - The counter logic is removed and `preempt` is tied to 0.
  - An owner keeps the grant as long as its `req` stays high, indefinitely.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum {IDLE, OWN, GAP}.
  - Default constants `ARB_NREQ_DEF`=4 and `ARB_MAX_HOLD_DEF`=16.
  - A function returning the index width for a given `NREQ`.
- Sub-module `rr_pick`: purely combinational rotating-priority encoder. Inputs are `req` and `ptr`; outputs are a `found` flag and a `winner` index. It is instantiated once inside `rr_arbiter`.

## Test plan
- **Reset mid-grant:** `NREQ`=4, `req`=4'b0010 granted, assert `rst` low mid-grant → `grant`=0, `grant_valid`=0 and `grant_id`=0 immediately, asynchronously. After release, with `req` still 4'b0010, `grant`=4'b0010 is visible one cycle after the first rising edge.
- **Single requester:** `req[2]` high for 5 cycles, then low → `grant`=4'b0100 for cycles 1..5, 0 in the GAP cycle, `grant_id`=2 while held.
- **Fairness:** `req`=4'b1111 held; each owner drops `req` after 2 cycles and re-raises it immediately.
  - Grant order 0,1,2,3,0.
  - Each grant lasts 2 cycles with one GAP between grants.
- **Wrap-around:** owner 3 releases while `req`=4'b1001 → next `grant`=4'b0001 (`ptr` wrapped to 0), not requester 3.
- **Preemption** (`RR_ARBITER_HOLD_LIMIT_EN` defined, `MAX_HOLD`=4):
  - `req`=4'b0011 held constant → `grant`=4'b0001 for 4 cycles, then a GAP with `preempt`=1.
  - Then `grant`=4'b0010 for 4 cycles, alternating.
- **Limit off** (`RR_ARBITER_HOLD_LIMIT_EN` undefined): `req`=4'b0011 for 100 cycles → `grant`=4'b0001 throughout, `preempt` never asserted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int ARB_NREQ_DEF     = 4;
    localparam int ARB_MAX_HOLD_DEF = 16;

    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first requester at or after ptr_i (mod NREQ) wins.
// Purely combinational, no backpressure.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NREQ = ARB_NREQ_DEF,
    localparam int IW   = arb_idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            found_o,
    output logic [IW-1:0]   winner_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr_i and i are both below NREQ, so one subtraction wraps the sum
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant locking and one GAP cycle between owners; grant one cycle after req.
// Optional hold-limit preemption under RR_ARBITER_HOLD_LIMIT_EN; requesters hold req until granted.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int NREQ     = ARB_NREQ_DEF,
    parameter  int MAX_HOLD = ARB_MAX_HOLD_DEF,
    localparam int IW       = arb_idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id,
    output logic            preempt
);

    if (NREQ < 2 || NREQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_chk
        $error("rr_arbiter: NREQ must be 2..16 and MAX_HOLD 1..255");
    end

    arb_state_t      state_q;
    logic [NREQ-1:0] grant_q;
    logic            grant_vld_q;
    logic [IW-1:0]   grant_id_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;

    logic            found;
    logic [IW-1:0]   winner;
    logic            owner_req;
    logic            limit_hit;
    logic            release_own;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    assign owner_req   = req[grant_id_q];
    assign release_own = (state_q == OWN) && (!owner_req || limit_hit);
    assign ptr_d       = (grant_id_q == IW'(NREQ-1)) ? '0 : grant_id_q + 1'b1;

`ifdef RR_ARBITER_HOLD_LIMIT_EN
    logic [7:0] hold_q;
    logic       preempt_q;

    // hold_q counts completed grant cycles, so the limit trips on the MAX_HOLD-th one
    assign limit_hit = (state_q == OWN) && (hold_q >= 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= limit_hit && owner_req;
            if (state_q != OWN || release_own) begin
                hold_q <= '0;
            end else if (hold_q != 8'(MAX_HOLD)) begin
                hold_q <= hold_q + 8'd1;
            end
        end
    end

    assign preempt = preempt_q;
`else
    assign limit_hit = 1'b0;
    assign preempt   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    if (found) begin
                        state_q     <= OWN;
                        grant_q     <= NREQ'(1) << winner;
                        grant_vld_q <= 1'b1;
                        grant_id_q  <= winner;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                OWN: begin
                    if (release_own) begin
                        state_q     <= GAP;
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        grant_id_q  <= '0;
                        ptr_q       <= ptr_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    grant_vld_q <= 1'b0;
                    grant_id_q  <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_vld_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (NREQ=4, MAX_HOLD=4); expectations queued per step, checked after each edge.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempt;

    always #5 clk = ~clk;

    rr_arbiter #(.NREQ(4), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic       p;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic exp_t mk(input logic [3:0] g, input logic p, input string tag);
        exp_t e;
        e.g   = g;
        e.v   = |g;
        e.id  = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) e.id = 2'(i);
        e.p   = p;
        e.tag = tag;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        n_chk++;
        assert ({grant, grant_valid, grant_id, preempt} === {e.g, e.v, e.id, e.p}) n_pass++;
        else $error("FAIL %s: got grant=%b vld=%b id=%0d pre=%b, want grant=%b vld=%b id=%0d pre=%b",
                    e.tag, grant, grant_valid, grant_id, preempt, e.g, e.v, e.id, e.p);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic p, input string tag);
        req = r;
        sb.push_back(mk(g, p, tag));
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    initial begin
        logic [3:0] oh;
        rst = 1'b0;
        req = 4'b0000;
        #2;
        compare(mk(4'b0000, 1'b0, "reset_state"));
        @(posedge clk);
        #1;
        compare(mk(4'b0000, 1'b0, "reset_held"));
        #3 rst = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, "idle");

        // fairness: all request, each owner keeps 2 cycles then drops for one edge
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            step(4'b1111, oh, 1'b0, "fair_grant");
            step(4'b1111, oh, 1'b0, "fair_hold");
            step(4'b1111 & ~oh, 4'b0000, 1'b0, "fair_gap");
        end
        step(4'b1111, 4'b0001, 1'b0, "fair_wrap0");
        step(4'b1110, 4'b0000, 1'b0, "fair_rel0");
        step(4'b0000, 4'b0000, 1'b0, "fair_idle");

        // single requester 2, held 5 cycles
        for (int k = 0; k < 5; k++) step(4'b0100, 4'b0100, 1'b0, "single_hold");
        step(4'b0000, 4'b0000, 1'b0, "single_gap");
        step(4'b0000, 4'b0000, 1'b0, "single_idle");

        // wrap-around: ptr=3 now; owner 3 releases, then 0 must beat 3
        step(4'b1000, 4'b1000, 1'b0, "wrap_own3");
        step(4'b1001, 4'b1000, 1'b0, "wrap_hold3");
        step(4'b0001, 4'b0000, 1'b0, "wrap_gap");
        step(4'b1001, 4'b0001, 1'b0, "wrap_ptr0");
        step(4'b0000, 4'b0000, 1'b0, "wrap_rel");
        step(4'b0000, 4'b0000, 1'b0, "wrap_idle");

        // asynchronous reset mid-grant
        step(4'b0010, 4'b0010, 1'b0, "rst_pre");
        #3 rst = 1'b0;
        #1;
        compare(mk(4'b0000, 1'b0, "rst_async"));
        @(posedge clk);
        #1;
        compare(mk(4'b0000, 1'b0, "rst_mid_held"));
        #3 rst = 1'b1;
        step(4'b0010, 4'b0010, 1'b0, "rst_regrant");
        step(4'b0000, 4'b0000, 1'b0, "rst_rel");
        step(4'b0000, 4'b0000, 1'b0, "rst_idle");

`ifdef RR_ARBITER_HOLD_LIMIT_EN
        // ptr=2: requester 0 wins first, then owners alternate under the limit
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 4; k++) step(4'b0011, 4'b0001, 1'b0, "limit_own0");
            step(4'b0011, 4'b0000, 1'b1, "limit_pre0");
            for (int k = 0; k < 4; k++) step(4'b0011, 4'b0010, 1'b0, "limit_own1");
            step(4'b0011, 4'b0000, 1'b1, "limit_pre1");
        end
        for (int k = 0; k < 4; k++) step(4'b0011, 4'b0001, 1'b0, "limit_own0b");
        step(4'b0000, 4'b0000, 1'b0, "limit_drop_at_limit");
        step(4'b0000, 4'b0000, 1'b0, "limit_idle");
`else
        step(4'b0011, 4'b0001, 1'b0, "nolimit_grant");
        for (int k = 1; k < 100; k++) step(4'b0011, 4'b0001, 1'b0, "nolimit_hold");
        step(4'b0000, 4'b0000, 1'b0, "nolimit_rel");
        step(4'b0000, 4'b0000, 1'b0, "nolimit_idle");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
